// File: rtl/cwc_fifo_pkg.sv
// rtl/cwc_fifo_pkg.sv - shared types and sizing for the CWC byte/bit FIFOs
package cwc_fifo_pkg;

  localparam int FIFO_DEPTH = 64;

  typedef logic [7:0] byte_t;

  // Occupancy counter width: must hold 0..depth inclusive
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_1_to_8_byte_ram.sv
// rtl/fifo_1_to_8_byte_ram.sv - DEPTHx8 simple dual-port RAM, sync write, registered sync read
module byte_ram
  import cwc_fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  byte_t         i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output byte_t         o_rd_data
);

  byte_t r_mem [DEPTH];
  byte_t r_q;

  // Write port; contents are deliberately never cleared
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port; the output register holds its value when no read is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_rd_en) begin
      r_q <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_q;

endmodule

// File: rtl/fifo_1_to_8.sv
// rtl/fifo_1_to_8.sv - serial-bit to MSB-first byte packing FIFO with zero-padding flush
module fifo_1_to_8
  import cwc_fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CW    = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din,
  input  logic          wr_en,
  input  logic          flush,
  input  logic          rd_en,
  output logic [7:0]    dout,
  output logic          valid,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] rd_data_count,
  output logic [2:0]    bit_count,
  output logic          overflow,
  output logic          underflow
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  byte_t         r_asm;
  logic [2:0]    r_bc;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_valid;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_flush_acc;
  logic          w_push;
  byte_t         w_asm_new;
  logic [CW-1:0] w_count_next;
  byte_t         w_rd_data;

  // Accept/push decisions; an accepted bit is merged before any flush so the
  // pushed byte always includes it, and a completing bit plus flush pushes once
  always_comb begin
    w_wr_acc  = wr_en && !r_full;
    w_rd_acc  = rd_en && !r_empty;
    w_asm_new = r_asm;
    if (w_wr_acc) begin
      w_asm_new[3'd7 - r_bc] = din;
    end
    w_flush_acc = flush && !r_full && ((r_bc != 3'd0) || w_wr_acc);
    w_push      = w_flush_acc || (w_wr_acc && (r_bc == 3'd7));
    w_count_next = r_count;
    if (w_push && !w_rd_acc) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_push && w_rd_acc) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Assembly register and bit counter; unwritten low bits stay zero after a push
  always_ff @(posedge clk) begin
    if (rst) begin
      r_asm <= '0;
      r_bc  <= '0;
    end else if (w_push) begin
      r_asm <= '0;
      r_bc  <= '0;
    end else if (w_wr_acc) begin
      r_asm <= w_asm_new;
      r_bc  <= r_bc + 3'd1;
    end
  end

  // Pointers, occupancy and flags; flags track the next count so they move with it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == FULL_COUNT);
      r_empty <= (w_count_next == '0);
    end
  end

  // Read-valid and one-cycle error pulses, judged on start-of-cycle flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_valid     <= w_rd_acc;
      r_overflow  <= (wr_en || flush) && r_full;
      r_underflow <= rd_en && r_empty;
    end
  end

  byte_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_asm_new),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign dout          = w_rd_data;
  assign valid         = r_valid;
  assign full          = r_full;
  assign empty         = r_empty;
  assign rd_data_count = r_count;
  assign bit_count     = r_bc;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

endmodule

// File: tb/tb_fifo_1_to_8.sv
// tb/tb_fifo_1_to_8.sv - directed self-checking bench for fifo_1_to_8
module tb_fifo_1_to_8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din = 1'b0;
  logic       wr_en = 1'b0;
  logic       flush = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] dout;
  logic       valid;
  logic       full;
  logic       empty;
  logic [6:0] rd_data_count;
  logic [2:0] bit_count;
  logic       overflow;
  logic       underflow;

  int n_cmp = 0;
  int n_err = 0;

  fifo_1_to_8 dut (
    .clk           (clk),
    .rst           (rst),
    .din           (din),
    .wr_en         (wr_en),
    .flush         (flush),
    .rd_en         (rd_en),
    .dout          (dout),
    .valid         (valid),
    .full          (full),
    .empty         (empty),
    .rd_data_count (rd_data_count),
    .bit_count     (bit_count),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Drive one cycle of inputs, then sample just after the edge
  task automatic tick(input logic w, input logic d, input logic f, input logic r);
    wr_en = w; din = d; flush = f; rd_en = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0; din = 1'b0; flush = 1'b0; rd_en = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tick(1'b1, b[i], 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({dout, valid, full, empty, rd_data_count, bit_count, overflow, underflow} !==
        {8'h00, 1'b0, 1'b0, 1'b1, 7'd0, 3'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got dout=%h v=%b f=%b e=%b cnt=%0d bc=%0d ov=%b un=%b expected 00 0 0 1 0 0 0 0",
               dout, valid, full, empty, rd_data_count, bit_count, overflow, underflow);
    end
  endtask

  task automatic test_basic();
    logic [15:0] bits;
    bits = 16'b0100_0000_0101_0101;
    do_reset();
    for (int i = 15; i >= 8; i--) tick(1'b1, bits[i], 1'b0, 1'b0);
    n_cmp++;
    if ({rd_data_count, empty} !== {7'd1, 1'b0}) begin
      n_err++; $display("FAIL basic_cnt1: got %0d/%b expected 1/0", rd_data_count, empty);
    end
    for (int i = 7; i >= 0; i--) tick(1'b1, bits[i], 1'b0, 1'b0);
    n_cmp++;
    if (rd_data_count !== 7'd2) begin
      n_err++; $display("FAIL basic_cnt2: got %0d expected 2", rd_data_count);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({dout, valid, rd_data_count} !== {8'h40, 1'b1, 7'd1}) begin
      n_err++; $display("FAIL basic_rd1: got %h/%b/%0d expected 40/1/1", dout, valid, rd_data_count);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({dout, valid, rd_data_count, empty} !== {8'h55, 1'b1, 7'd0, 1'b1}) begin
      n_err++; $display("FAIL basic_rd2: got %h/%b/%0d/%b expected 55/1/0/1", dout, valid, rd_data_count, empty);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({dout, valid} !== {8'h55, 1'b0}) begin
      n_err++; $display("FAIL basic_hold: got %h/%b expected 55/0", dout, valid);
    end
  endtask

  task automatic test_message();
    logic [7:0] exp;
    do_reset();
    for (int k = 0; k < 47; k++) write_byte(8'(k + 1));
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({rd_data_count, bit_count} !== {7'd47, 3'd4}) begin
      n_err++; $display("FAIL msg_preflush: got %0d/%0d expected 47/4", rd_data_count, bit_count);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({rd_data_count, bit_count} !== {7'd48, 3'd0}) begin
      n_err++; $display("FAIL msg_flush: got %0d/%0d expected 48/0", rd_data_count, bit_count);
    end
    for (int k = 0; k < 48; k++) begin
      exp = (k == 47) ? 8'hE0 : 8'(k + 1);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if ({dout, valid} !== {exp, 1'b1}) begin
        n_err++; $display("FAIL msg_byte%0d: got %h/%b expected %h/1", k, dout, valid, exp);
      end
    end
    n_cmp++;
    if (empty !== 1'b1) begin
      n_err++; $display("FAIL msg_empty: got %b expected 1", empty);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 64; i++) write_byte(8'(i) ^ 8'h3C);
    n_cmp++;
    if ({full, rd_data_count} !== {1'b1, 7'd64}) begin
      n_err++; $display("FAIL full_flag: got %b/%0d expected 1/64", full, rd_data_count);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({overflow, bit_count, rd_data_count} !== {1'b1, 3'd0, 7'd64}) begin
      n_err++; $display("FAIL full_drop: got %b/%0d/%0d expected 1/0/64", overflow, bit_count, rd_data_count);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if ({overflow, valid, dout, bit_count, rd_data_count, full} !== {1'b1, 1'b1, 8'h3C, 3'd0, 7'd63, 1'b0}) begin
      n_err++; $display("FAIL full_rdwr: got ov=%b v=%b d=%h bc=%0d c=%0d f=%b expected 1 1 3c 0 63 0",
                        overflow, valid, dout, bit_count, rd_data_count, full);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({overflow, bit_count} !== {1'b0, 3'd1}) begin
      n_err++; $display("FAIL full_after_rd: got %b/%0d expected 0/1", overflow, bit_count);
    end
  endtask

  task automatic test_underflow_concurrent();
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({underflow, valid} !== {1'b1, 1'b0}) begin
      n_err++; $display("FAIL under_empty: got %b/%b expected 1/0", underflow, valid);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (underflow !== 1'b0) begin
      n_err++; $display("FAIL under_pulse: got %b expected 0", underflow);
    end
    for (int i = 7; i >= 1; i--) tick(1'b1, 1'(8'h11 >> i), 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if ({underflow, valid, rd_data_count} !== {1'b1, 1'b0, 7'd1}) begin
      n_err++; $display("FAIL under_race: got %b/%b/%0d expected 1/0/1", underflow, valid, rd_data_count);
    end
    for (int i = 7; i >= 1; i--) tick(1'b1, 1'(8'h22 >> i), 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({dout, valid, rd_data_count} !== {8'h11, 1'b1, 7'd1}) begin
      n_err++; $display("FAIL concur_rdpush: got %h/%b/%0d expected 11/1/1", dout, valid, rd_data_count);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({dout, valid, rd_data_count} !== {8'h22, 1'b1, 7'd0}) begin
      n_err++; $display("FAIL concur_rd2: got %h/%b/%0d expected 22/1/0", dout, valid, rd_data_count);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 7; i >= 1; i--) tick(1'b1, 1'(8'hA5 >> i), 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({rd_data_count, bit_count} !== {7'd1, 3'd0}) begin
      n_err++; $display("FAIL flush_8th: got %0d/%0d expected 1/0", rd_data_count, bit_count);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({rd_data_count, overflow} !== {7'd1, 1'b0}) begin
      n_err++; $display("FAIL flush_noop: got %0d/%b expected 1/0", rd_data_count, overflow);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({rd_data_count, bit_count} !== {7'd2, 3'd0}) begin
      n_err++; $display("FAIL flush_bit2: got %0d/%0d expected 2/0", rd_data_count, bit_count);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (dout !== 8'hA5) begin
      n_err++; $display("FAIL flush_rd1: got %h expected a5", dout);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (dout !== 8'hC0) begin
      n_err++; $display("FAIL flush_rd2: got %h expected c0", dout);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({rd_data_count, bit_count, valid} !== {7'd2, 3'd5, 1'b1}) begin
      n_err++; $display("FAIL midrst_pre: got %0d/%0d/%b expected 2/5/1", rd_data_count, bit_count, valid);
    end
    do_reset();
    n_cmp++;
    if ({dout, valid, full, empty, rd_data_count, bit_count, overflow, underflow} !==
        {8'h00, 1'b0, 1'b0, 1'b1, 7'd0, 3'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL midrst_state: got dout=%h v=%b f=%b e=%b cnt=%0d bc=%0d ov=%b un=%b expected 00 0 0 1 0 0 0 0",
               dout, valid, full, empty, rd_data_count, bit_count, overflow, underflow);
    end
    write_byte(8'h9C);
    n_cmp++;
    if ({rd_data_count, bit_count} !== {7'd1, 3'd0}) begin
      n_err++; $display("FAIL midrst_cnt: got %0d/%0d expected 1/0", rd_data_count, bit_count);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({dout, valid} !== {8'h9C, 1'b1}) begin
      n_err++; $display("FAIL midrst_byte0: got %h/%b expected 9c/1", dout, valid);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_message();
    test_full();
    test_underflow_concurrent();
    test_flush();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
